// File: rtl/pipe_pkg.sv
// pipe_pkg: shared stage indices, default widths and tag entry layout for the hazard unit
package pipe_pkg;
    localparam int STG_EX = 0;
    localparam int STG_MA = 1;
    localparam int STG_WB = 2;
    localparam int XLEN_DEF = 16;
    localparam int NREG_DEF = 8;
    localparam int TAG_VALID = 0;
    localparam int TAG_WR_EN = 1;
    localparam int TAG_IS_LOAD = 2;
    localparam int TAG_DEST = 3;
endpackage

// File: rtl/pipe_hazard_unit_fwd_match.sv
// fwd_match: youngest-first producer matcher over the tag pipeline for one RR operand
module fwd_match
    import pipe_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int RIDX = 3,
    parameter int LOAD_READY_STAGE = 1,
    parameter int R0_ZERO = 0,
    parameter int SEL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                               req,
    input  logic [RIDX-1:0]                    src,
    input  logic [DEPTH*(RIDX+TAG_DEST)-1:0]   tags,
    output logic [DEPTH-1:0]                   hit,
    output logic                               hazard,
    output logic [SEL_W-1:0]                   sel
);
    localparam int TW = RIDX + TAG_DEST;
    logic en;
    logic found;
    logic late;
    always_comb begin
        en = req && !(R0_ZERO != 0 && src == '0);
        found = 1'b0;
        late = 1'b0;
        sel = '0;
        // Scan oldest to youngest so the youngest matching producer is the last one kept
        for (int i = DEPTH - 1; i >= STG_EX; i--) begin
            if (en && tags[i*TW + TAG_VALID] && tags[i*TW + TAG_WR_EN]
                && tags[i*TW + TAG_DEST +: RIDX] == src) begin
                found = 1'b1;
                late = tags[i*TW + TAG_IS_LOAD] && i < LOAD_READY_STAGE;
                sel = SEL_W'(i);
            end
        end
        hazard = found && late;
        hit = (found && !late) ? DEPTH'(1) << sel : '0;
    end
endmodule

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: RR-stage operand forwarding, load-use interlock and saturating stall counter
module pipe_hazard_unit
    import pipe_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int RIDX = $clog2(NREG),
    parameter int DEPTH = STG_WB + 1,
    parameter int LOAD_READY_STAGE = STG_MA,
    parameter int CNT_W = 16,
    parameter int R0_ZERO = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rr_valid,
    input  logic [RIDX-1:0]       rr_src_a,
    input  logic [RIDX-1:0]       rr_src_b,
    input  logic                  rr_use_a,
    input  logic                  rr_use_b,
    input  logic [RIDX-1:0]       rr_dest,
    input  logic                  rr_wr_en,
    input  logic                  rr_is_load,
    input  logic                  flush,
    input  logic [DEPTH*XLEN-1:0] stage_data,
    input  logic [XLEN-1:0]       rf_a_data,
    input  logic [XLEN-1:0]       rf_b_data,
    input  logic                  stat_clr,
    output logic [XLEN-1:0]       fwd_a_data,
    output logic [XLEN-1:0]       fwd_b_data,
    output logic [DEPTH-1:0]      fwd_hit_a,
    output logic [DEPTH-1:0]      fwd_hit_b,
    output logic                  stall,
    output logic [CNT_W-1:0]      stall_count
);
    localparam int TW = RIDX + TAG_DEST;
    localparam int SEL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    logic [DEPTH-1:0][TW-1:0] tag_q, tag_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic haz_a, haz_b;
    logic [SEL_W-1:0] sel_a, sel_b;

    fwd_match #(
        .DEPTH(DEPTH), .RIDX(RIDX), .LOAD_READY_STAGE(LOAD_READY_STAGE), .R0_ZERO(R0_ZERO), .SEL_W(SEL_W)
    ) u_match_a (
        .req(rr_valid & rr_use_a), .src(rr_src_a), .tags(tag_q),
        .hit(fwd_hit_a), .hazard(haz_a), .sel(sel_a)
    );

    fwd_match #(
        .DEPTH(DEPTH), .RIDX(RIDX), .LOAD_READY_STAGE(LOAD_READY_STAGE), .R0_ZERO(R0_ZERO), .SEL_W(SEL_W)
    ) u_match_b (
        .req(rr_valid & rr_use_b), .src(rr_src_b), .tags(tag_q),
        .hit(fwd_hit_b), .hazard(haz_b), .sel(sel_b)
    );

    always_comb begin
        stall = rr_valid && !flush && (haz_a || haz_b);
        fwd_a_data = |fwd_hit_a ? stage_data[sel_a*XLEN +: XLEN] : rf_a_data;
        fwd_b_data = |fwd_hit_b ? stage_data[sel_b*XLEN +: XLEN] : rf_b_data;
        // A stalled or flushed RR instruction leaves a bubble in EX
        tag_d[0] = {rr_dest, rr_is_load, rr_wr_en, rr_valid && !stall && !flush};
        for (int i = 1; i < DEPTH; i++) tag_d[i] = tag_q[i-1];
        cnt_d = stat_clr ? '0 : (stall && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
        stall_count = cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_q <= '0;
            cnt_q <= '0;
        end else begin
            tag_q <= tag_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb_pipe_hazard_unit: directed vectors with a scoreboard queue checked by an independent monitor
module tb_pipe_hazard_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic rr_valid, rr_use_a, rr_use_b, rr_wr_en, rr_is_load, flush, stat_clr;
    logic [2:0] rr_src_a, rr_src_b, rr_dest;
    logic [47:0] stage_data;
    logic [15:0] rf_a_data, rf_b_data;
    logic [15:0] fwd_a_data, fwd_b_data, fwd_a_data2, fwd_b_data2;
    logic [2:0] fwd_hit_a, fwd_hit_b, fwd_hit_a2, fwd_hit_b2;
    logic stall, stall2;
    logic [15:0] stall_count;
    logic [1:0] stall_count2;

    pipe_hazard_unit u_dut (
        .clk(clk), .rst(rst), .rr_valid(rr_valid), .rr_src_a(rr_src_a), .rr_src_b(rr_src_b),
        .rr_use_a(rr_use_a), .rr_use_b(rr_use_b), .rr_dest(rr_dest), .rr_wr_en(rr_wr_en),
        .rr_is_load(rr_is_load), .flush(flush), .stage_data(stage_data), .rf_a_data(rf_a_data),
        .rf_b_data(rf_b_data), .stat_clr(stat_clr), .fwd_a_data(fwd_a_data), .fwd_b_data(fwd_b_data),
        .fwd_hit_a(fwd_hit_a), .fwd_hit_b(fwd_hit_b), .stall(stall), .stall_count(stall_count)
    );

    pipe_hazard_unit #(.CNT_W(2), .R0_ZERO(1)) u_dut2 (
        .clk(clk), .rst(rst), .rr_valid(rr_valid), .rr_src_a(rr_src_a), .rr_src_b(rr_src_b),
        .rr_use_a(rr_use_a), .rr_use_b(rr_use_b), .rr_dest(rr_dest), .rr_wr_en(rr_wr_en),
        .rr_is_load(rr_is_load), .flush(flush), .stage_data(stage_data), .rf_a_data(rf_a_data),
        .rf_b_data(rf_b_data), .stat_clr(stat_clr), .fwd_a_data(fwd_a_data2), .fwd_b_data(fwd_b_data2),
        .fwd_hit_a(fwd_hit_a2), .fwd_hit_b(fwd_hit_b2), .stall(stall2), .stall_count(stall_count2)
    );

    typedef struct {
        int id;
        bit st;
        bit [2:0] ha, hb, ha2;
        int da, db, da2;
        int c1, c2;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int n_chk = 0;
    int n_fail = 0;

    task automatic cmp(input int id, input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL vec%0d %s: got %h expected %h", id, nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            me = q.pop_front();
            cmp(me.id, "stall", 16'(stall), 16'(me.st));
            cmp(me.id, "hit_a", 16'(fwd_hit_a), 16'(me.ha));
            cmp(me.id, "hit_b", 16'(fwd_hit_b), 16'(me.hb));
            if (me.da >= 0) cmp(me.id, "data_a", fwd_a_data, 16'(me.da));
            if (me.db >= 0) cmp(me.id, "data_b", fwd_b_data, 16'(me.db));
            cmp(me.id, "count", stall_count, 16'(me.c1));
            cmp(me.id, "stall2", 16'(stall2), 16'(me.st));
            cmp(me.id, "hit_a2", 16'(fwd_hit_a2), 16'(me.ha2));
            cmp(me.id, "hit_b2", 16'(fwd_hit_b2), 16'(me.hb));
            if (me.da2 >= 0) cmp(me.id, "data_a2", fwd_a_data2, 16'(me.da2));
            cmp(me.id, "count2", 16'(stall_count2), 16'(me.c2));
        end
    end

    task automatic iss(input bit v, input bit [2:0] sa, input bit ua, input bit [2:0] sb, input bit ub,
                       input bit [2:0] d, input bit we, input bit ld);
        rr_valid = v; rr_src_a = sa; rr_use_a = ua; rr_src_b = sb; rr_use_b = ub;
        rr_dest = d; rr_wr_en = we; rr_is_load = ld;
    endtask

    task automatic step(input int id, input bit st, input bit [2:0] ha, input bit [2:0] hb,
                        input int da, input int db, input int c1, input int c2,
                        input int ha2 = -1, input int da2 = -2);
        exp_t e;
        e.id = id; e.st = st; e.ha = ha; e.hb = hb; e.da = da; e.db = db; e.c1 = c1; e.c2 = c2;
        e.ha2 = (ha2 < 0) ? ha : 3'(ha2);
        e.da2 = (da2 == -2) ? da : da2;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    function automatic int sat3(input int x);
        return (x > 3) ? 3 : x;
    endfunction

    localparam int RA = 16'h0A0A;
    localparam int RB = 16'h0B0B;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; flush = 1'b0; stat_clr = 1'b0;
        rf_a_data = 16'h0A0A; rf_b_data = 16'h0B0B;
        stage_data = {16'h5555, 16'hBEEF, 16'h1234};
        iss(1, 3, 1, 3, 1, 5, 1, 0);
        @(posedge clk);
        #1;
        step(0, 0, 3'b000, 3'b000, RA, RB, 0, 0);
        rst = 1'b1;
        iss(1, 0, 0, 0, 0, 3, 1, 0); step(1, 0, 3'b000, 3'b000, RA, RB, 0, 0);
        iss(1, 3, 1, 0, 0, 4, 1, 0); step(2, 0, 3'b001, 3'b000, 16'h1234, RB, 0, 0);
        iss(1, 1, 1, 2, 1, 6, 1, 0); step(3, 0, 3'b000, 3'b000, RA, RB, 0, 0);
        iss(1, 0, 0, 0, 0, 2, 1, 1); step(4, 0, 3'b000, 3'b000, RA, RB, 0, 0);
        iss(1, 0, 0, 2, 1, 7, 1, 0); step(5, 1, 3'b000, 3'b000, RA, -1, 0, 0);
        step(6, 0, 3'b000, 3'b010, RA, 16'hBEEF, 1, 1);
        iss(1, 0, 0, 0, 0, 5, 1, 0);
        for (int k = 0; k < 3; k++) step(7 + k, 0, 3'b000, 3'b000, RA, RB, 1, 1);
        stage_data = {16'h000A, 16'h000B, 16'h000C};
        iss(1, 5, 1, 5, 1, 7, 0, 0); step(10, 0, 3'b001, 3'b001, 16'h000C, 16'h000C, 1, 1);
        iss(1, 0, 0, 0, 0, 1, 1, 1); step(11, 0, 3'b000, 3'b000, RA, RB, 1, 1);
        iss(1, 0, 0, 0, 0, 1, 1, 0); step(12, 0, 3'b000, 3'b000, RA, RB, 1, 1);
        iss(1, 1, 1, 0, 0, 7, 0, 0); step(13, 0, 3'b001, 3'b000, 16'h000C, RB, 1, 1);
        iss(1, 0, 0, 0, 0, 4, 1, 1); step(14, 0, 3'b000, 3'b000, RA, RB, 1, 1);
        flush = 1'b1;
        iss(1, 4, 1, 0, 0, 4, 1, 0); step(15, 0, 3'b000, 3'b000, -1, RB, 1, 1);
        flush = 1'b0;
        iss(1, 4, 1, 0, 0, 7, 0, 0); step(16, 0, 3'b010, 3'b000, 16'h000B, RB, 1, 1);
        iss(1, 0, 0, 0, 0, 6, 1, 1); step(17, 0, 3'b000, 3'b000, RA, RB, 1, 1);
        iss(1, 6, 1, 0, 0, 6, 1, 1);
        for (int k = 0; k < 4; k++) begin
            step(18 + 2*k, 1, 3'b000, 3'b000, -1, RB, 1 + k, sat3(1 + k));
            step(19 + 2*k, 0, 3'b010, 3'b000, 16'h000B, RB, 2 + k, sat3(2 + k));
        end
        stat_clr = 1'b1;
        iss(0, 0, 0, 0, 0, 0, 0, 0); step(26, 0, 3'b000, 3'b000, RA, RB, 5, 3);
        stat_clr = 1'b0;
        step(27, 0, 3'b000, 3'b000, RA, RB, 0, 0);
        iss(1, 0, 0, 0, 0, 0, 1, 0); step(28, 0, 3'b000, 3'b000, RA, RB, 0, 0);
        iss(1, 0, 1, 0, 0, 7, 0, 0); step(29, 0, 3'b001, 3'b000, 16'h000C, RB, 0, 0, 0, RA);
        iss(1, 0, 0, 0, 0, 3, 1, 1); step(30, 0, 3'b000, 3'b000, RA, RB, 0, 0);
        iss(1, 0, 0, 3, 1, 7, 1, 0); step(31, 1, 3'b000, 3'b000, RA, -1, 0, 0);
        rst = 1'b0;
        step(32, 0, 3'b000, 3'b000, RA, RB, 0, 0);
        rst = 1'b1;
        step(33, 0, 3'b000, 3'b000, RA, RB, 0, 0);
        for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
        if (q.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
